// File: rtl/phy_pkg.sv
// Shared constants and types for the PHY receive lane deserialiser.
// Holds the symbol defaults, the sync FSM state type and the loss counter width.
package phy_pkg;

  localparam logic [7:0] COM_SYM_DEF  = 8'hBC;
  localparam logic [7:0] IDLE_SYM_DEF = 8'h7C;
  localparam int         LOSS_W       = 8;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ALIGN = 2'd1,
    SYNC  = 2'd2
  } phyState_t;

endpackage

// File: rtl/phy_word_shifter.sv
// Serial-to-parallel shift register with a word bit counter.
// alignClear restarts word framing so the next bit begins a fresh word.
module phy_word_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              serialIn,
  input  logic              alignClear,
  output logic [DATA_W-1:0] nxt,
  output logic              wordDone
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     bitCnt;

  assign nxt      = {sr[DATA_W-2:0], serialIn};
  assign wordDone = (bitCnt == LAST_BIT);

  // Shift one bit per clock and track the position within the word.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      sr     <= '0;
      bitCnt <= '0;
    end else begin
      sr <= nxt;
      if (alignClear || wordDone)
        bitCnt <= '0;
      else
        bitCnt <= bitCnt + 1'b1;
    end
  end

endmodule

// File: rtl/phy_rx_lane_deser.sv
// Receive lane deserialiser: COM alignment, sync supervision and
// round-robin distribution of data words over the output lanes.
module phy_rx_lane_deser
  import phy_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                NUM_LANES  = 4,
  parameter logic [DATA_W-1:0] COM_SYM    = DATA_W'(COM_SYM_DEF),
  parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(IDLE_SYM_DEF),
  parameter int                SYNC_COUNT = 4,
  parameter int                MAX_GAP    = 16
) (
  input  logic                        clk_32f,
  input  logic                        reset,
  input  logic                        serial_in,
  output logic                        active,
  output logic [NUM_LANES*DATA_W-1:0] data_out,
  output logic [NUM_LANES-1:0]        valid_out,
  output logic                        word_strobe,
  output logic [LOSS_W-1:0]           loss_count
);

  localparam int CC_W = $clog2(SYNC_COUNT + 1);
  localparam int GW   = $clog2(MAX_GAP + 1);
  localparam int LP_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  localparam logic [CC_W-1:0] SYNC_LAST = CC_W'(SYNC_COUNT - 1);
  localparam logic [GW-1:0]   GAP_LAST  = GW'(MAX_GAP - 1);
  localparam logic [LP_W-1:0] LANE_LAST = LP_W'(NUM_LANES - 1);

  phyState_t state, stateNext;

  logic [DATA_W-1:0]           nxt;
  logic                        wordDone;
  logic                        alignClear;
  logic                        isCom;
  logic                        isIdle;
  logic [CC_W-1:0]             comCnt, comCntNext;
  logic [GW-1:0]               gapCnt, gapCntNext;
  logic [LP_W-1:0]             lanePtr, lanePtrNext;
  logic                        activeNext;
  logic [NUM_LANES*DATA_W-1:0] dataNext;
  logic [NUM_LANES-1:0]        validNext;
  logic                        strobeNext;
  logic [LOSS_W-1:0]           lossNext;

  phy_word_shifter #(
    .DATA_W(DATA_W)
  ) uShifter (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .serialIn  (serial_in),
    .alignClear(alignClear),
    .nxt       (nxt),
    .wordDone  (wordDone)
  );

  assign isCom  = (nxt == COM_SYM);
  assign isIdle = (nxt == IDLE_SYM);

  // Register FSM state, counters and all outputs.
  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      state       <= HUNT;
      comCnt      <= '0;
      gapCnt      <= '0;
      lanePtr     <= '0;
      active      <= 1'b0;
      data_out    <= '0;
      valid_out   <= '0;
      word_strobe <= 1'b0;
      loss_count  <= '0;
    end else begin
      state       <= stateNext;
      comCnt      <= comCntNext;
      gapCnt      <= gapCntNext;
      lanePtr     <= lanePtrNext;
      active      <= activeNext;
      data_out    <= dataNext;
      valid_out   <= validNext;
      word_strobe <= strobeNext;
      loss_count  <= lossNext;
    end
  end

  // Next-state, lane demux and COM-gap supervision.
  always_comb begin
    stateNext   = state;
    comCntNext  = comCnt;
    gapCntNext  = gapCnt;
    lanePtrNext = lanePtr;
    activeNext  = active;
    dataNext    = data_out;
    validNext   = valid_out;
    strobeNext  = 1'b0;
    lossNext    = loss_count;
    alignClear  = 1'b0;
    unique case (state)
      HUNT: begin
        if (isCom) begin
          alignClear = 1'b1;
          comCntNext = CC_W'(1);
          if (SYNC_COUNT == 1) begin
            stateNext   = SYNC;
            activeNext  = 1'b1;
            lanePtrNext = '0;
            gapCntNext  = '0;
          end else begin
            stateNext = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (wordDone) begin
          if (!isCom) begin
            stateNext  = HUNT;
            comCntNext = '0;
          end else if (comCnt == SYNC_LAST) begin
            stateNext   = SYNC;
            comCntNext  = comCnt + 1'b1;
            activeNext  = 1'b1;
            lanePtrNext = '0;
            gapCntNext  = '0;
          end else begin
            comCntNext = comCnt + 1'b1;
          end
        end
      end
      SYNC: begin
        if (wordDone) begin
          if (isCom) begin
            lanePtrNext = '0;
            gapCntNext  = '0;
          end else if (gapCnt == GAP_LAST) begin
            stateNext  = HUNT;
            activeNext = 1'b0;
            validNext  = '0;
            comCntNext = '0;
            gapCntNext = '0;
            if (loss_count != '1)
              lossNext = loss_count + 1'b1;
          end else begin
            strobeNext = 1'b1;
            gapCntNext = gapCnt + 1'b1;
            if (isIdle) begin
              validNext[lanePtr] = 1'b0;
            end else begin
              dataNext[lanePtr*DATA_W +: DATA_W] = nxt;
              validNext[lanePtr] = 1'b1;
            end
            if (lanePtr == LANE_LAST)
              lanePtrNext = '0;
            else
              lanePtrNext = lanePtr + 1'b1;
          end
        end
      end
      default: stateNext = HUNT;
    endcase
  end

endmodule

// File: tb/tb_phy_rx_lane_deser.sv
// Directed self-checking bench for phy_rx_lane_deser.
// Serial bits driven MSB first; outputs sampled 1ns after each rising edge.
module tb_phy_rx_lane_deser;

  logic        clk_32f = 1'b0;
  logic        reset = 1'b0;
  logic        serial_in = 1'b0;
  logic        active;
  logic [31:0] data_out;
  logic [3:0]  valid_out;
  logic        word_strobe;
  logic [7:0]  loss_count;

  int nTests = 0;
  int nFail = 0;
  int strobes;

  phy_rx_lane_deser dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .serial_in  (serial_in),
    .active     (active),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .word_strobe(word_strobe),
    .loss_count (loss_count)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic sendBit(input logic b);
    serial_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic sendWord(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) sendBit(w[i]);
    if (word_strobe) strobes++;
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (2) sendBit(1'($urandom_range(0, 1)));
    reset = 1'b1;
  endtask

  task automatic syncUp();
    doReset();
    repeat (4) sendWord(8'hBC);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) sendBit(1'($urandom_range(0, 1)));
    nTests++;
    if ({active, word_strobe, valid_out, data_out, loss_count} !== 46'd0) begin
      nFail++;
      $display("FAIL reset: act=%b strb=%b v=%b d=%h loss=%0d required all 0",
               active, word_strobe, valid_out, data_out, loss_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_acquisition();
    doReset();
    repeat (3) sendBit(1'b0);
    for (int k = 0; k < 3; k++) begin
      sendWord(8'hBC);
      nTests++;
      if (active !== 1'b0) begin
        nFail++;
        $display("FAIL acq_early%0d: active=%b required 0", k, active);
      end
    end
    for (int i = 7; i >= 1; i--) sendBit(1'(8'hBC >> i));
    nTests++;
    if (active !== 1'b0) begin
      nFail++;
      $display("FAIL acq_prebit: active=%b required 0", active);
    end
    sendBit(1'b0);
    nTests++;
    if (active !== 1'b1) begin
      nFail++;
      $display("FAIL acq_rise: active=%b required 1", active);
    end
  endtask

  task automatic test_failed_acq();
    doReset();
    repeat (3) sendWord(8'hBC);
    sendWord(8'h55);
    nTests++;
    if (active !== 1'b0) begin
      nFail++;
      $display("FAIL facq_55: active=%b required 0", active);
    end
    for (int k = 0; k < 3; k++) begin
      sendWord(8'hBC);
      nTests++;
      if (active !== 1'b0) begin
        nFail++;
        $display("FAIL facq_bc%0d: active=%b required 0", k, active);
      end
    end
    sendWord(8'hBC);
    nTests++;
    if (active !== 1'b1) begin
      nFail++;
      $display("FAIL facq_sync: active=%b required 1", active);
    end
  endtask

  task automatic test_demux();
    sendWord(8'hBC);
    sendWord(8'h99);
    sendWord(8'h98);
    sendWord(8'h97);
    sendWord(8'hBC);
    nTests++;
    if (word_strobe !== 1'b0 || data_out !== 32'h00979899) begin
      nFail++;
      $display("FAIL demux_com: strb=%b d=%h required 0 00979899",
               word_strobe, data_out);
    end
    strobes = 0;
    sendWord(8'h11);
    sendWord(8'h22);
    sendWord(8'h7C);
    nTests++;
    if (valid_out[2] !== 1'b0 || data_out[23:16] !== 8'h97) begin
      nFail++;
      $display("FAIL demux_idle: v2=%b d2=%h required 0 97",
               valid_out[2], data_out[23:16]);
    end
    sendWord(8'h44);
    nTests++;
    if (data_out !== 32'h44972211 || valid_out !== 4'b1011) begin
      nFail++;
      $display("FAIL demux_lanes: d=%h v=%b required 44972211 1011",
               data_out, valid_out);
    end
    nTests++;
    if (strobes !== 4) begin
      nFail++;
      $display("FAIL demux_strobes: got %0d required 4", strobes);
    end
  endtask

  task automatic test_wrap();
    sendWord(8'hBC);
    for (int i = 0; i < 5; i++) sendWord(8'hA0 + 8'(i));
    nTests++;
    if (data_out !== 32'hA3A2A1A4 || valid_out !== 4'b1111) begin
      nFail++;
      $display("FAIL wrap: d=%h v=%b required A3A2A1A4 1111",
               data_out, valid_out);
    end
  endtask

  task automatic test_gap_boundary();
    sendWord(8'hBC);
    for (int i = 0; i < 15; i++) sendWord(8'h20 + 8'(i));
    sendWord(8'hBC);
    nTests++;
    if (active !== 1'b1 || loss_count !== 8'd0) begin
      nFail++;
      $display("FAIL gap_edge_com: act=%b loss=%0d required 1 0",
               active, loss_count);
    end
    sendWord(8'h55);
    nTests++;
    if (data_out[7:0] !== 8'h55 || word_strobe !== 1'b1) begin
      nFail++;
      $display("FAIL gap_edge_next: d0=%h strb=%b required 55 1",
               data_out[7:0], word_strobe);
    end
  endtask

  task automatic test_gap_loss();
    sendWord(8'hBC);
    for (int i = 0; i < 15; i++) sendWord(8'h10 + 8'(i));
    nTests++;
    if (active !== 1'b1 || data_out !== 32'h1B1E1D1C) begin
      nFail++;
      $display("FAIL gap_15: act=%b d=%h required 1 1B1E1D1C",
               active, data_out);
    end
    sendWord(8'h1F);
    nTests++;
    if (active !== 1'b0 || valid_out !== 4'b0000 || loss_count !== 8'd1) begin
      nFail++;
      $display("FAIL gap_loss: act=%b v=%b loss=%0d required 0 0000 1",
               active, valid_out, loss_count);
    end
    nTests++;
    if (data_out !== 32'h1B1E1D1C || word_strobe !== 1'b0) begin
      nFail++;
      $display("FAIL gap_hold: d=%h strb=%b required 1B1E1D1C 0",
               data_out, word_strobe);
    end
  endtask

  task automatic test_reset_mid();
    syncUp();
    sendWord(8'h33);
    nTests++;
    if (active !== 1'b1 || data_out[7:0] !== 8'h33) begin
      nFail++;
      $display("FAIL mid_pre: act=%b d0=%h required 1 33",
               active, data_out[7:0]);
    end
    for (int i = 7; i >= 3; i--) sendBit(1'(8'hF0 >> i));
    reset = 1'b0;
    sendBit(1'b0);
    nTests++;
    if ({active, word_strobe, valid_out, data_out, loss_count} !== 46'd0) begin
      nFail++;
      $display("FAIL mid_reset: act=%b strb=%b v=%b d=%h loss=%0d required all 0",
               active, word_strobe, valid_out, data_out, loss_count);
    end
    reset = 1'b1;
    repeat (3) sendWord(8'hBC);
    nTests++;
    if (active !== 1'b0) begin
      nFail++;
      $display("FAIL mid_resync3: active=%b required 0", active);
    end
    sendWord(8'hBC);
    nTests++;
    if (active !== 1'b1) begin
      nFail++;
      $display("FAIL mid_resync4: active=%b required 1", active);
    end
  endtask

  initial begin
    test_reset();
    test_acquisition();
    test_failed_acq();
    test_demux();
    test_wrap();
    test_gap_boundary();
    test_gap_loss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
